spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Receive-side counterpart to the LIF neuron. It turns a neuron's spike output back into numeric values: a spike count over a fixed window (rate code) and the interval between the last two spikes (temporal code). It sits downstream of one neuron's spike line and produces 8-bit results with one-cycle valid strobes for readout logic or a following layer.

Parameters:
WINDOW_LOG2, 8, window length is 2^WINDOW_LOG2 enabled cycles; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset; all state is reset while 0.
en  input  1  count enable; when 0 all counters and FSM hold.
clear  input  1  synchronous restart of window and interval tracking.
spike  input  1  level spike from a neuron; each enabled cycle high = one event.
rate  output  8  spike count of last completed window, saturating at 255.
rate_valid  output  1  one-cycle pulse when rate updates.
isi  output  8  cycles between last two spikes, saturating at 255.
isi_valid  output  1  one-cycle pulse when isi updates.

Behaviour:
- Reset (rst_n=0, asynchronous): win_cnt=0, spk_cnt=0, isi_cnt=0, FSM=WAIT_FIRST, rate=0, isi=0, rate_valid=0, isi_valid=0.
- All outputs are registered. rate_valid and isi_valid are high only in the cycle after their update edge.
- Priority each edge: clear > en=0 > normal operation.
- clear=1: win_cnt, spk_cnt and isi_cnt go to 0 and FSM goes to WAIT_FIRST. rate and isi hold. Both valids are 0. A spike in that cycle is ignored.
- en=0 (clear=0): all state, rate and isi hold. Valids are 0. Spikes are ignored. The window is stretched, not restarted.
- Window counter:
  - win_cnt is WINDOW_LOG2 bits and increments on each enabled cycle, wrapping from 2^WINDOW_LOG2-1 to 0.
  - spk_cnt is 8 bits and saturates at 255. It increments on each enabled cycle with spike=1.
- Window boundary (enabled cycle with win_cnt = 2^WINDOW_LOG2-1):
  - rate <= sat255(spk_cnt + spike); a spike on the boundary cycle belongs to the ending window.
  - spk_cnt <= 0 and rate_valid <= 1.
  - The first boundary after reset or clear is the 2^WINDOW_LOG2-th enabled cycle.
- Interval FSM, two states:
  - WAIT_FIRST:
    - Enabled spike: go to TIMING, isi_cnt <= 1, no isi_valid.
    - Otherwise stay; isi_cnt stays 0.
  - TIMING:
    - Enabled spike: isi <= isi_cnt, isi_valid <= 1, isi_cnt <= 1, stay in TIMING.
    - Enabled cycle without spike: isi_cnt <= min(isi_cnt+1, 255).
  - Spikes on consecutive enabled cycles report isi=1. isi=255 means an interval of at least 255 cycles.
- Simultaneous events: a window boundary and an ISI update in the same cycle both take effect, and both valids may pulse together.
- Reset asserted mid-window: the partial count is discarded and outputs go to 0 immediately, without waiting for a clock edge.

Test Plan:
- Async reset: drive activity, then pull rst_n low between edges -> rate, isi and both valids read 0 before the next edge. Release rst_n -> first rate_valid arrives 2^WINDOW_LOG2 enabled cycles later.
- WINDOW_LOG2=4, en=1, spike every 4th cycle -> rate=4 with rate_valid once per 16 cycles. isi_valid pulses with isi=4 on every spike after the first, and not on the first.
- WINDOW_LOG2=8, spike held at 1 -> rate=255 (saturated, not 0). isi=1 and isi_valid asserts on every cycle from the second spike onward.
- One spike, then 300 quiet cycles, then one spike -> isi=255 with isi_valid for one cycle. A following spike 3 cycles later -> isi=3.
- WINDOW_LOG2=4, en dropped for 10 cycles mid-window with spike=1 throughout -> boundary delayed by exactly 10 cycles. Spikes during en=0 are not counted, and rate equals the enabled spikes only.
- clear pulsed mid-window after 5 spikes -> rate and isi hold their old values with no valid pulse. Next rate_valid comes 2^WINDOW_LOG2 enabled cycles after clear, with a count that excludes pre-clear spikes. The first spike after clear produces no isi_valid.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike train decoder: windowed spike count (rate) and
// inter-spike interval (isi), each with a one-cycle valid strobe.
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  input  logic       spike,
  output logic [7:0] rate,
  output logic       rate_valid,
  output logic [7:0] isi,
  output logic       isi_valid
);

  typedef enum logic {
    WAIT_FIRST,
    TIMING
  } state_t;

  state_t state, state_nx;

  logic [WINDOW_LOG2-1:0] win_cnt, win_nx;
  logic [7:0] spk_cnt, spk_nx;
  logic [7:0] isi_cnt, isi_cnt_nx;
  logic [7:0] rate_nx, isi_nx;
  logic       rv_nx, iv_nx;
  logic       boundary;
  logic [8:0] spk_sum;

  assign boundary = &win_cnt;
  assign spk_sum  = {1'b0, spk_cnt} + {8'd0, spike};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FIRST;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      isi_cnt    <= '0;
      rate       <= '0;
      isi        <= '0;
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
    end else begin
      state      <= state_nx;
      win_cnt    <= win_nx;
      spk_cnt    <= spk_nx;
      isi_cnt    <= isi_cnt_nx;
      rate       <= rate_nx;
      isi        <= isi_nx;
      rate_valid <= rv_nx;
      isi_valid  <= iv_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    win_nx     = win_cnt;
    spk_nx     = spk_cnt;
    isi_cnt_nx = isi_cnt;
    rate_nx    = rate;
    isi_nx     = isi;
    rv_nx      = 1'b0;
    iv_nx      = 1'b0;

    if (clear) begin
      state_nx   = WAIT_FIRST;
      win_nx     = '0;
      spk_nx     = '0;
      isi_cnt_nx = '0;
    end else if (en) begin
      win_nx = win_cnt + WINDOW_LOG2'(1);

      // boundary-cycle spike is folded into the ending window
      if (boundary) begin
        rate_nx = spk_sum[8] ? 8'hff : spk_sum[7:0];
        spk_nx  = '0;
        rv_nx   = 1'b1;
      end else if (spike && spk_cnt != 8'hff) begin
        spk_nx = spk_cnt + 8'd1;
      end

      unique case (state)
        WAIT_FIRST: begin
          if (spike) begin
            state_nx   = TIMING;
            isi_cnt_nx = 8'd1;
          end
        end
        TIMING: begin
          if (spike) begin
            isi_nx     = isi_cnt;
            iv_nx      = 1'b1;
            isi_cnt_nx = 8'd1;
          end else if (isi_cnt != 8'hff) begin
            isi_cnt_nx = isi_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder against a timestamp
// reference model, with WINDOW_LOG2 = 4 and 8 instances in parallel.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst_n, en, clear, spike;
  logic [7:0] rate4, isi4, rate8, isi8;
  logic rv4, iv4, rv8, iv8;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_LOG2(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .spike(spike), .rate(rate4), .rate_valid(rv4),
    .isi(isi4), .isi_valid(iv4)
  );

  spike_rate_decoder #(.WINDOW_LOG2(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .spike(spike), .rate(rate8), .rate_valid(rv8),
    .isi(isi8), .isi_valid(iv8)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d exp %0d (t=%0t)",
                  tag, got, exp, $time);
  endtask

  // model: enabled-cycle timestamps since last restart
  int wlen[2] = '{16, 256};
  int ecnt[2], wsp[2], last[2];
  int m_rate[2], m_isi[2];
  bit m_rv[2], m_iv[2];

  function automatic void m_restart();
    for (int i = 0; i < 2; i++) begin
      ecnt[i] = 0; wsp[i] = 0; last[i] = -1;
      m_rv[i] = 0; m_iv[i] = 0;
    end
  endfunction

  function automatic void m_reset();
    m_restart();
    for (int i = 0; i < 2; i++) begin
      m_rate[i] = 0; m_isi[i] = 0;
    end
  endfunction

  function automatic void m_step(bit e, bit c, bit s);
    int t;
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 0; m_iv[i] = 0;
    end
    if (c) begin
      m_restart();
      return;
    end
    if (!e) return;
    for (int i = 0; i < 2; i++) begin
      t = ecnt[i];
      if (s) begin
        wsp[i]++;
        if (last[i] >= 0) begin
          m_isi[i] = (t - last[i] > 255) ? 255 : t - last[i];
          m_iv[i] = 1;
        end
        last[i] = t;
      end
      if ((t + 1) % wlen[i] == 0) begin
        m_rate[i] = (wsp[i] > 255) ? 255 : wsp[i];
        m_rv[i] = 1;
        wsp[i] = 0;
      end
      ecnt[i]++;
    end
  endfunction

  task automatic compare();
    check("rate4", 32'(rate4), 32'(m_rate[0]));
    check("rate_valid4", 32'(rv4), 32'(m_rv[0]));
    check("isi4", 32'(isi4), 32'(m_isi[0]));
    check("isi_valid4", 32'(iv4), 32'(m_iv[0]));
    check("rate8", 32'(rate8), 32'(m_rate[1]));
    check("rate_valid8", 32'(rv8), 32'(m_rv[1]));
    check("isi8", 32'(isi8), 32'(m_isi[1]));
    check("isi_valid8", 32'(iv8), 32'(m_iv[1]));
  endtask

  task automatic cyc(input bit e, input bit c, input bit s);
    @(negedge clk);
    en = e; clear = c; spike = s;
    @(posedge clk);
    m_step(e, c, s);
    #1 compare();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    compare();
    @(negedge clk);
    en = 1'b0; clear = 1'b0; spike = 1'b0;
    @(posedge clk);
    #1 compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int dens;

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; spike = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 compare();
    @(negedge clk);
    rst_n = 1'b1;

    // periodic spikes, period 4
    for (int i = 0; i < 80; i++) cyc(1, 0, (i % 4) == 0);

    // spike held high: saturation and isi=1
    for (int i = 0; i < 600; i++) cyc(1, 0, 1);

    // long quiet interval, then short one
    cyc(1, 0, 1);
    for (int i = 0; i < 300; i++) cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);

    // en dropped mid-window with spike asserted
    async_reset();
    for (int i = 0; i < 6; i++) cyc(1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    for (int i = 0; i < 40; i++) cyc(1, 0, 1);

    // clear after 5 spikes
    for (int i = 0; i < 10; i++) cyc(1, 0, (i % 2) == 0);
    cyc(1, 1, 1);
    for (int i = 0; i < 300; i++) cyc(1, 0, (i % 3) == 1);

    // randomized traffic with occasional clear / reset
    for (int blk = 0; blk < 8; blk++) begin
      dens = $urandom_range(0, 100);
      for (int i = 0; i < 500; i++)
        cyc($urandom_range(0, 9) != 0,
            $urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < dens);
      if (blk % 3 == 2) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
